// File: rtl/scale_out_buffer.sv
// scale_out_buffer: realigns pipeline valids, rounds and saturates 32-bit results to OUT_W,
// and queues them in a FWFT FIFO with sticky saturation and drop flags.
module scale_out_buffer #(
    parameter int LATENCY   = 1,
    parameter int FRAC_DROP = 8,
    parameter int OUT_W     = 16,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    input  logic [31:0]                data_i,
    input  logic                       clear_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OUT_W-1:0]           data_o,
    output logic                       sat_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic signed [32:0] MAX_V = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0] MIN_V = -(33'sd1 <<< (OUT_W - 1));
    localparam logic signed [32:0] RND   = 33'sd1 <<< (FRAC_DROP - 1);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [OUT_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]      lvl_q, lvl_d;
    logic               sat_q, sat_d, ovf_q, ovf_d;
    logic               arr_v, push, pop, full, sat_hit;
    logic signed [32:0] shifted;
    logic [OUT_W-1:0]   res;

    always_comb begin
        // 33-bit headroom keeps 0x7FFFFFFF + RND from wrapping negative
        shifted = ($signed({data_i[31], data_i}) + RND) >>> FRAC_DROP;
        sat_hit = (shifted > MAX_V) || (shifted < MIN_V);
        res     = (shifted > MAX_V) ? MAX_V[OUT_W-1:0] :
                  (shifted < MIN_V) ? MIN_V[OUT_W-1:0] : shifted[OUT_W-1:0];
        arr_v   = vld_q[LATENCY-1];
        vld_d   = LATENCY'({vld_q, in_valid_i});
        full    = lvl_q == LW'(DEPTH);
        pop     = (lvl_q != '0) && out_ready_i;
        push    = arr_v && (!full || pop);
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        lvl_d   = lvl_q + LW'(push) - LW'(pop);
        sat_d   = (push && sat_hit) || (sat_q && !clear_i);
        ovf_d   = (arr_v && full && !pop) || (ovf_q && !clear_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
            sat_q <= sat_d;
            ovf_q <= ovf_d;
            if (push) mem_q[wr_q] <= res;
        end
    end

    assign out_valid_o = lvl_q != '0;
    assign data_o      = out_valid_o ? mem_q[rd_q] : '0;
    assign sat_o       = sat_q;
    assign overflow_o  = ovf_q;
    assign level_o     = lvl_q;
endmodule

// File: tb/tb_scale_out_buffer.sv
// tb_scale_out_buffer: directed checks of rounding, saturation, FIFO full/drop and reset flush.
module tb_scale_out_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        clear = 1'b0;
    logic        ready = 1'b0;
    logic        v1, s1, o1, v3, s3, o3;
    logic [15:0] d1, d3;
    logic [2:0]  l1, l3;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    scale_out_buffer #(.LATENCY(1), .FRAC_DROP(8), .OUT_W(16), .DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .data_i(data_in), .clear_i(clear),
        .out_valid_o(v1), .out_ready_i(ready), .data_o(d1), .sat_o(s1),
        .overflow_o(o1), .level_o(l1));

    scale_out_buffer #(.LATENCY(3), .FRAC_DROP(8), .OUT_W(16), .DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .data_i(data_in), .clear_i(clear),
        .out_valid_o(v3), .out_ready_i(ready), .data_o(d3), .sat_o(s3),
        .overflow_o(o3), .level_o(l3));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send1(input logic [31:0] d);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        data_in = d;
        step();
        data_in = '0;
    endtask

    task automatic pop1;
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_valid1", {31'd0, v1}, 32'd0);
        chk("rst_data1", {16'd0, d1}, 32'd0);
        chk("rst_flags1", {30'd0, s1, o1}, 32'd0);
        chk("rst_level1", {29'd0, l1}, 32'd0);
        chk("rst_level3", {29'd0, l3}, 32'd0);

        send1(32'h0000_1280);
        chk("rnd_pos_valid", {31'd0, v1}, 32'd1);
        chk("rnd_pos_data", {16'd0, d1}, 32'h0013);
        chk("rnd_pos_sat", {31'd0, s1}, 32'd0);
        pop1();
        send1(32'hFFFF_FE80);
        chk("rnd_neg_m1", {16'd0, d1}, 32'hFFFF);
        pop1();
        send1(32'hFFFF_FE7F);
        chk("rnd_neg_m2", {16'd0, d1}, 32'hFFFE);
        pop1();
        chk("sat_clear_before", {31'd0, s1}, 32'd0);

        send1(32'h7FFF_FFFF);
        chk("sat_pos_data", {16'd0, d1}, 32'h7FFF);
        chk("sat_pos_flag", {31'd0, s1}, 32'd1);
        pop1();
        send1(32'h8000_0000);
        chk("sat_neg_data", {16'd0, d1}, 32'h8000);
        pop1();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("sat_cleared", {31'd0, s1}, 32'd0);
        chk("empty_after_sat", {29'd0, l1}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 5);
            data_in = (i > 0) ? (32'(i) << 8) : 32'd0;
            step();
        end
        data_in = '0;
        chk("full_level", {29'd0, l1}, 32'd4);
        chk("full_overflow", {31'd0, o1}, 32'd1);
        chk("full_sat_none", {31'd0, s1}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_%0d", i), {16'd0, d1}, 32'(i));
            pop1();
        end
        chk("drain_empty", {31'd0, v1}, 32'd0);
        chk("drain_data_zero", {16'd0, d1}, 32'd0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("no_underflow", {29'd0, l1}, 32'd0);
        chk("ovf_held", {31'd0, o1}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("ovf_cleared", {31'd0, o1}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4);
            data_in = (i > 0) ? (32'(9 + i) << 8) : 32'd0;
            step();
        end
        chk("refill_level", {29'd0, l1}, 32'd4);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        data_in = 32'd14 << 8;
        ready = 1'b1;
        step();
        ready = 1'b0;
        data_in = '0;
        chk("fullpop_level", {29'd0, l1}, 32'd4);
        chk("fullpop_ovf", {31'd0, o1}, 32'd0);
        chk("fullpop_head", {16'd0, d1}, 32'd11);
        ready = 1'b1;
        repeat (4) step();
        chk("fullpop_drained", {29'd0, l1}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            data_in = 32'(k + 20) << 8;
            step();
            chk($sformatf("stream_level_%0d", k), {31'd0, (l1 <= 3'd1)}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        ready = 1'b0;
        chk("stream_ovf", {31'd0, o1}, 32'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        data_in = 32'h0000_0100;
        repeat (5) step();
        chk("l3_queued", {29'd0, l3}, 32'd2);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_level", {29'd0, l3}, 32'd0);
        chk("midrst_valid", {31'd0, v3}, 32'd0);
        chk("midrst_flags", {30'd0, s3, o3}, 32'd0);
        chk("midrst_data", {16'd0, d3}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("midrst_flush_%0d", k), {29'd0, l3}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scale_out_buffer.md
Name: scale_out_buffer

Overview:
- Sink stage directly downstream of the shift-right-add scaling pipeline.
- Tracks which pipeline output cycles carry real samples, using a valid delay line matched to the pipeline latency.
- Rounds and saturates each 32-bit signed result to OUT_W bits.
- Buffers results in a small FIFO that presents a valid/ready stream to the consumer. The upstream pipeline has no backpressure, so when the FIFO cannot accept a sample, the sample is dropped and flagged.

Parameters:
- LATENCY, 1, cycles from in_valid_i to the matching data_i; 1..8
- FRAC_DROP, 8, LSBs removed by rounding; 1..16
- OUT_W, 16, signed output width; 8..31
- DEPTH, 4, FIFO entries; power of two, 2..16

Ports:
- clk, in, 1, rising-edge clock
- rst, in, 1, synchronous active-high reset
- in_valid_i, in, 1, high in the cycle a sample enters the upstream pipeline
- data_i, in, 32, signed result from the pipeline's data_o
- clear_i, in, 1, clears the sticky flags
- out_valid_o, out, 1, FIFO non-empty
- out_ready_i, in, 1, consumer accepts the head entry
- data_o, out, OUT_W, signed head-of-FIFO value
- sat_o, out, 1, sticky: at least one stored sample was saturated
- overflow_o, out, 1, sticky: at least one sample was dropped because the FIFO was full
- level_o, out, $clog2(DEPTH)+1, current FIFO occupancy

Behaviour:
- Reset (rst=1 at a clock edge):
  - Delay line and FIFO are cleared; pointers and level go to 0.
  - out_valid_o=0, data_o=0, sat_o=0, overflow_o=0, level_o=0.
  - Samples in flight are discarded; a reset mid-stream drops them and raises no flag.
- Valid alignment:
  - in_valid_i is shifted through a LATENCY-deep register chain.
  - The chain output, arr_v, is high exactly in the cycle data_i holds that sample's result.
  - data_i is ignored whenever arr_v=0.
- Arithmetic (combinational on data_i):
  - Sign-extend data_i to 33 bits.
  - Add 1<<(FRAC_DROP-1) (round half up toward +inf).
  - Arithmetic right shift by FRAC_DROP.
  - If the result is greater than 2^(OUT_W-1)-1, clamp to that value. If it is less than -2^(OUT_W-1), clamp to -2^(OUT_W-1). Clamping sets sat_hit.
  - No intermediate wrap: 0x7FFFFFFF must saturate, not go negative.
- FIFO:
  - First-word-fall-through. data_o = mem[rd_ptr] when non-empty, 0 when empty.
  - out_valid_o = (level != 0).
  - pop = out_valid_o & out_ready_i.
  - push = arr_v & (level < DEPTH | pop). When full, a simultaneous pop frees a slot and the push is accepted in the same cycle.
  - push and pop together: level is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Entry latency: a sample with arr_v at cycle t appears on data_o with out_valid_o=1 at cycle t+1 (written at edge t).
- Flags:
  - If arr_v=1, the FIFO is full and pop=0, the sample is dropped and overflow_o sets at the next edge.
  - sat_o sets at the edge where a saturated sample is pushed. Dropped samples do not set sat_o.
  - clear_i=1 clears both flags at the next edge. If a set event occurs in the same cycle as clear_i, the set wins.
  - Both flags hold until clear_i or rst.
- out_ready_i while empty has no effect; level never underflows.

Test Plan:
- Rounding, positive (LATENCY=1): in_valid_i pulse, then next cycle data_i=0x00001280. Expect out_valid_o=1 the following cycle, data_o=0x0013, sat_o=0.
- Rounding, negative: data_i=0xFFFFFE80 (-384). Expect data_o=0xFFFF (-1). Then data_i=0xFFFFFE7F. Expect data_o=0xFFFE.
- Saturation: data_i=0x7FFFFFFF, then 0x80000000. Expect data_o=0x7FFF then 0x8000, and sat_o=1 after the first push. clear_i pulse clears sat_o.
- Full/drop: out_ready_i=0, 5 consecutive valid samples 1..5 (each <<8) with DEPTH=4. Expect level_o=4, overflow_o=1, sample 5 lost. Drain yields 1,2,3,4 in order.
- Full with simultaneous pop: FIFO full, out_ready_i=1 in the same cycle as arr_v. Expect the push accepted, level_o stays 4, overflow_o=0. Continuous stream with ready held high keeps level_o at or below 1 and drops nothing.
- Reset mid-operation: LATENCY=3, 3 valids in flight and 2 entries queued, assert rst for 1 cycle. Expect level_o=0, out_valid_o=0, flags 0, and no output from the in-flight samples.
